// File: rtl/dmem_pkg.sv
// Shared widths and buffer-entry type for the data memory and its posted-write buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Feature macro DMEM_WBUF_EN selects the buffered build in dmem_wbuf.
package dmem_pkg;

  localparam int DMEM_WORDS_DEFAULT = 256;
  localparam int WBUF_DEPTH_DEFAULT = 4;

  // Widest word index a 32-bit byte address can carry; any MEM_WORDS fits in it.
  localparam int WORD_IDX_W = 30;

  typedef logic [WORD_IDX_W-1:0] wordIdx_t;

  typedef struct packed {
    logic        valid;
    wordIdx_t    index;
    logic [31:0] data;
  } wbufEntry_t;

  // Word-index width for a RAM of the given depth.
  function automatic int idxWidth(input int words);
    return $clog2(words);
  endfunction

  // Occupancy width: one extra bit so full and empty are distinguishable.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: circular store queue with youngest-match lookup for load forwarding.
// Latency: push visible to lookup one cycle after the accepting edge; head drains on popEn.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pushEn,
  input  wordIdx_t                   pushIdx,
  input  logic [31:0]                pushData,
  input  logic                       popEn,
  input  wordIdx_t                   lookupIdx,
  output wbufEntry_t                 headEntry,
  output logic                       hitVld,
  output logic [31:0]                hitData,
  output logic [cntWidth(DEPTH)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] validQ;
  wordIdx_t         idxQ  [DEPTH];
  logic [31:0]      dataQ [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W-1:0] lookSlot;

  assign full      = (count == cntWidth(DEPTH)'(DEPTH));
  assign empty     = (count == '0);
  assign headEntry = '{valid: validQ[headPtr], index: idxQ[headPtr], data: dataQ[headPtr]};

  // Pointers, valid bits and occupancy; push after pop so a full-buffer swap keeps the slot valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      validQ  <= '0;
    end else begin
      if (popEn) begin
        validQ[headPtr] <= 1'b0;
        headPtr         <= headPtr + 1'b1;
      end
      if (pushEn) begin
        validQ[tailPtr] <= 1'b1;
        tailPtr         <= tailPtr + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; no reset needed because the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!reset && pushEn) begin
      idxQ[tailPtr]  <= pushIdx;
      dataQ[tailPtr] <= pushData;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store to that word.
  always_comb begin
    hitVld   = 1'b0;
    hitData  = '0;
    lookSlot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lookSlot = headPtr + PTR_W'(k);
      if (validQ[lookSlot] && (idxQ[lookSlot] == lookupIdx)) begin
        hitVld  = 1'b1;
        hitData = dataQ[lookSlot];
      end
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Data memory with optional posted-write buffer (enabled by macro DMEM_WBUF_EN); single-port RAM.
// Latency: loads combinational; buffered stores reach RAM >=1 cycle later, forwarded meanwhile.
// Backpressure: MemStall when a store meets a full buffer during a load (no drain slot).
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS  = DMEM_WORDS_DEFAULT,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            MemWriteM,
  input  logic                            MemtoRegM,
  input  logic [31:0]                     ALUOutM,
  input  logic [31:0]                     WriteDataM,
  output logic [31:0]                     DmmRD,
  output logic                            MemStall,
  output logic [cntWidth(WBUF_DEPTH)-1:0] DEBUG_WbufCount
);

  localparam int IDX_W = idxWidth(MEM_WORDS);

  logic [31:0]      ram [MEM_WORDS];
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      ramRd;

  assign wordIdx = ALUOutM[IDX_W+1:2];
  assign ramRd   = ram[wordIdx];

`ifdef DMEM_WBUF_EN

  logic        pushEn;
  logic        drainEn;
  logic        bufFull;
  logic        bufEmpty;
  logic        hitVld;
  logic [31:0] hitData;
  wbufEntry_t  headEntry;
  logic        unusedBits;

  // A load owns the RAM port, so draining only happens in non-load cycles.
  assign drainEn  = ~bufEmpty & ~MemtoRegM;
  assign MemStall = MemWriteM & bufFull & MemtoRegM;
  assign pushEn   = MemWriteM & ~MemStall;

  assign unusedBits = ^{ALUOutM[31:IDX_W+2], ALUOutM[1:0], headEntry.valid,
                        headEntry.index[WORD_IDX_W-1:IDX_W]};

  wbuf_fifo #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .pushEn   (pushEn),
    .pushIdx  (WORD_IDX_W'(wordIdx)),
    .pushData (WriteDataM),
    .popEn    (drainEn),
    .lookupIdx(WORD_IDX_W'(wordIdx)),
    .headEntry(headEntry),
    .hitVld   (hitVld),
    .hitData  (hitData),
    .count    (DEBUG_WbufCount),
    .full     (bufFull),
    .empty    (bufEmpty)
  );

  // Retire the oldest buffered store into RAM; RAM itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && drainEn) begin
      ram[headEntry.index[IDX_W-1:0]] <= headEntry.data;
    end
  end

  // Buffered data is newer than RAM; a same-cycle store is not yet in the buffer.
  assign DmmRD = hitVld ? hitData : ramRd;

`else

  logic unusedBits;

  assign unusedBits      = ^{ALUOutM[31:IDX_W+2], ALUOutM[1:0], MemtoRegM};
  assign MemStall        = 1'b0;
  assign DEBUG_WbufCount = '0;
  assign DmmRD           = ramRd;

  // Stores write RAM directly at the edge; a same-cycle load still sees the old word.
  always_ff @(posedge clk) begin
    if (!reset && MemWriteM) begin
      ram[wordIdx] <= WriteDataM;
    end
  end

`endif

endmodule

// File: tb/tb_dmem_wbuf.sv
module tb_dmem_wbuf;

`ifdef DMEM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic        MemtoRegM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] DmmRD;
  logic        MemStall;
  logic [2:0]  DEBUG_WbufCount;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expQ[$];
  logic [31:0] model [256];

  always #5 clk = ~clk;

  dmem_wbuf #(
    .MEM_WORDS (256),
    .WBUF_DEPTH(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .MemWriteM      (MemWriteM),
    .MemtoRegM      (MemtoRegM),
    .ALUOutM        (ALUOutM),
    .WriteDataM     (WriteDataM),
    .DmmRD          (DmmRD),
    .MemStall       (MemStall),
    .DEBUG_WbufCount(DEBUG_WbufCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkCnt(input string tag, input int exp);
    chk({tag, " count"}, {29'b0, DEBUG_WbufCount}, 32'(exp));
  endtask

  // One memory-stage cycle: drive after negedge, check combinational outputs, let the edge pass.
  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic expStall, input string tag);
    logic [31:0] expRd;
    @(negedge clk);
    MemWriteM  = w;
    MemtoRegM  = r;
    ALUOutM    = a;
    WriteDataM = d;
    if (r) expQ.push_back(model[a[9:2]]);
    #1;
    chk({tag, " stall"}, {31'b0, MemStall}, {31'b0, expStall});
    if (r) begin
      expRd = expQ.pop_front();
      chk({tag, " load"}, DmmRD, expRd);
    end
    @(posedge clk);
    #1;
    if (w && !expStall) model[a[9:2]] = d;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a would-be stalling store/load pattern on the inputs.
    reset      = 1'b1;
    MemWriteM  = 1'b1;
    MemtoRegM  = 1'b1;
    ALUOutM    = 32'h40;
    WriteDataM = 32'hEEEE_EEEE;
    #1;
    chkCnt("reset", 0);
    chk("reset stall", {31'b0, MemStall}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    MemWriteM = 1'b0;
    MemtoRegM = 1'b0;

    // Store then load next cycle: forwarded from the buffer (or RAM when unbuffered).
    step(1, 0, 32'h40, 32'hDEAD_BEEF, 0, "st40");  chkCnt("st40", WBUF ? 1 : 0);
    step(0, 1, 32'h40, 32'h0,         0, "ld40");  chkCnt("ld40", WBUF ? 1 : 0);
    step(1, 0, 32'h0,  32'h0000_00A5, 0, "st0");   chkCnt("st0", WBUF ? 1 : 0);
    step(0, 1, 32'h0,  32'h0,         0, "ld0");   chkCnt("ld0", WBUF ? 1 : 0);
    idle("idle0");                                 chkCnt("idle0", 0);

    // Two stores to one word; the later one must win in both forwarding and RAM.
    step(1, 0, 32'h80, 32'h7, 0, "st80a");
    idle("idle1");
    step(1, 1, 32'h80, 32'h11, 0, "st80b");  chkCnt("st80b", WBUF ? 1 : 0);
    step(1, 1, 32'h80, 32'h22, 0, "st80c");  chkCnt("st80c", WBUF ? 2 : 0);
    step(0, 1, 32'h80, 32'h0,  0, "ld80a");  chkCnt("ld80a", WBUF ? 2 : 0);
    idle("idle2");
    idle("idle3");                           chkCnt("drain80", 0);
    step(0, 1, 32'h80, 32'h0,  0, "ld80b");

    // Same-cycle store and load to one word return the prior value.
    step(1, 0, 32'h10, 32'h5, 0, "st10a");
    idle("idle4");                           chkCnt("idle4", 0);
    step(1, 1, 32'h10, 32'h99, 0, "stld10");
    step(0, 1, 32'h10, 32'h0,  0, "ld10");
    idle("idle5");

    // Fill the buffer while loads block draining, then overflow with a fifth store.
    step(1, 1, 32'h40, 32'h1, 0, "fill1");  chkCnt("fill1", WBUF ? 1 : 0);
    step(1, 1, 32'h0,  32'h2, 0, "fill2");  chkCnt("fill2", WBUF ? 2 : 0);
    step(1, 1, 32'h80, 32'h3, 0, "fill3");  chkCnt("fill3", WBUF ? 3 : 0);
    step(1, 1, 32'h10, 32'h4, 0, "fill4");  chkCnt("fill4", WBUF ? 4 : 0);
    step(1, 1, 32'h40, 32'h55, WBUF, "full5");  chkCnt("full5", WBUF ? 4 : 0);
    step(1, 0, 32'h40, 32'h55, 0,    "swap5");  chkCnt("swap5", WBUF ? 4 : 0);
    step(0, 1, 32'h40, 32'h0, 0, "ldyoung");
    step(0, 1, 32'h10, 32'h0, 0, "ld10b");
    repeat (4) idle("drainall");
    chkCnt("drainall", 0);
    step(0, 1, 32'h40, 32'h0, 0, "ram40");
    step(0, 1, 32'h0,  32'h0, 0, "ram0");

    // Buffer three stores, then reset asynchronously mid-cycle.
    step(1, 1, 32'h0,  32'hB1, 0, "pre1");
    step(1, 1, 32'h80, 32'hB2, 0, "pre2");
    step(1, 1, 32'h10, 32'hB3, 0, "pre3");  chkCnt("pre3", WBUF ? 3 : 0);
    @(negedge clk);
    MemWriteM  = 1'b1;
    MemtoRegM  = 1'b1;
    ALUOutM    = 32'h40;
    WriteDataM = 32'hEEEE_EEEE;
    #2;
    reset = 1'b1;
    #1;
    chkCnt("asyncrst", 0);
    chk("asyncrst stall", {31'b0, MemStall}, 32'd0);
    @(posedge clk);
    #1;
    chkCnt("rsthold", 0);
    @(negedge clk);
    reset     = 1'b0;
    MemWriteM = 1'b0;
    MemtoRegM = 1'b0;
`ifdef DMEM_WBUF_EN
    model[0]    = 32'h2;
    model[8'h20] = 32'h3;
    model[4]    = 32'h4;
`endif
    step(0, 1, 32'h0,  32'h0, 0, "post0");
    step(0, 1, 32'h80, 32'h0, 0, "post80");
    step(0, 1, 32'h10, 32'h0, 0, "post10");
    step(0, 1, 32'h40, 32'h0, 0, "post40");
    chkCnt("end", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf.md
DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: number of 32-bit data-memory words; power of two.
REQ-002 SHALL have parameter WBUF_DEPTH, default 4: number of posted-write buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port MemWriteM, input, 1 bit: store request from the memory stage.
REQ-006 SHALL have port MemtoRegM, input, 1 bit: load request from the memory stage; it occupies the RAM port for that cycle.
REQ-007 SHALL have port ALUOutM, input, 32 bits: byte address; the word index is ALUOutM[log2(MEM_WORDS)+1:2], and the upper and [1:0] bits are ignored.
REQ-008 SHALL have port WriteDataM, input, 32 bits: store data.
REQ-009 SHALL have port DmmRD, output, 32 bits: combinational load data.
REQ-010 SHALL have port MemStall, output, 1 bit: store not accepted this cycle; the requester holds MemWriteM, ALUOutM and WriteDataM.
REQ-011 SHALL have port DEBUG_WbufCount, output, log2(WBUF_DEPTH)+1 bits: current buffer occupancy.

Function
REQ-012 SHALL model RAM as a single-port array; per cycle exactly one of {load read, buffer drain} uses the port, and a load has priority.
REQ-013 SHALL enqueue {word index, data} at the tail on a rising edge when MemWriteM=1 and MemStall=0.
REQ-014 SHALL drain the head entry into RAM on a rising edge when the buffer is non-empty and MemtoRegM=0.
REQ-015 SHALL allow enqueue and drain in the same cycle, including when full; occupancy is then unchanged.
REQ-016 SHALL assert MemStall combinationally iff MemWriteM=1, the buffer is full, and MemtoRegM=1 (no drain possible).
REQ-017 SHALL compute DmmRD as RAM[index], overridden by the data of the youngest valid buffer entry whose index matches.
REQ-018 SHALL NOT forward a store presented in the same cycle as a load to the same word to DmmRD; the load returns the prior value.
REQ-019 SHALL drive DmmRD as don't-care-safe (RAM/forward value) when MemtoRegM=0; consumers ignore it.
REQ-020 SHALL wrap head and tail pointers modulo WBUF_DEPTH; full/empty are distinguished by the extra occupancy bit.
REQ-021 SHALL commit multiple buffered stores to the same word in order, so the last store wins.
REQ-022 SHALL have a latency from store acceptance to RAM visibility of at least 1 cycle; data remains visible via forwarding meanwhile.

Reset
REQ-023 SHALL, while reset=1, empty the buffer (pointers=0, all valid bits=0), drive DEBUG_WbufCount=0 and MemStall=0, and write nothing to RAM.
REQ-024 SHALL discard buffered but undrained stores on reset mid-operation, and SHALL NOT reset RAM contents.

Configuration
REQ-025 SHALL, with macro DMEM_WBUF_EN defined, implement the posted-write buffer as specified above.
REQ-026 SHALL, without DMEM_WBUF_EN, write RAM directly on the rising edge when MemWriteM=1, tie MemStall=0 and DEBUG_WbufCount=0, and make DmmRD a pure RAM read.

Structure
REQ-027 SHALL place MEM_WORDS/WBUF_DEPTH derived width constants and the buffer-entry typedef {valid, index, data} in shared package dmem_pkg.
REQ-028 SHALL implement the buffer as one sub-module, wbuf_fifo (storage, pointers, occupancy, youngest-match lookup); dmem_wbuf holds the RAM and arbitration.

Verification
REQ-029 SHALL cover: store 0xDEADBEEF @0x40, then load 0x40 the next cycle -> DmmRD=0xDEADBEEF via forwarding, DEBUG_WbufCount=1.
REQ-030 SHALL cover: 4 stores with MemtoRegM=1 held throughout, then a 5th store -> MemStall=1 and count=4; drop MemtoRegM -> 5th store accepted, count stays 4.
REQ-031 SHALL cover: stores 0x11 then 0x22 @0x80, then a load -> 0x22; after the drain completes, RAM[0x20]=0x22.
REQ-032 SHALL cover: store and load to 0x10 in the same cycle, with RAM[4]=0x5 -> DmmRD=0x5.
REQ-033 SHALL cover: 3 stores buffered, assert reset asynchronously mid-cycle -> count=0 immediately; RAM unchanged and later loads return old values.
REQ-034 SHALL cover: build without DMEM_WBUF_EN, store 0xA5 @0x0 -> load on the next cycle returns 0xA5, and MemStall never asserts.
